// File: rtl/pwls_seq_pkg.sv
// Shared constants for the piecewise-linear multichannel sequencer:
// FSM states, register field codes and waveform modes.
package pwls_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_e;

  localparam logic [1:0] FIELD_MANT  = 2'd0;
  localparam logic [1:0] FIELD_OCT   = 2'd1;
  localparam logic [1:0] FIELD_AMP   = 2'd2;
  localparam logic [1:0] FIELD_PHASE = 2'd3;

  localparam logic MODE_SAW = 1'b0;
  localparam logic MODE_TRI = 1'b1;

endpackage

// File: rtl/pwls_seq_wave.sv
// Combinational waveform shaper: phase to saw/triangle, then scaled down
// by the channel's amplitude shift.
module pwls_seq_wave
  import pwls_seq_pkg::*;
#(
  parameter int BITS = 12
) (
  input  logic [BITS-1:0] i_phase,
  input  logic            i_mode,
  input  logic [2:0]      i_amp_shift,
  output logic [BITS-1:0] o_contrib
);

  logic [BITS-1:0] w_wave;

  // Triangle folds the upper half of the phase back down at double slope.
  always_comb begin
    w_wave = i_phase;
    if (i_mode == MODE_TRI) begin
      if (i_phase[BITS-1]) begin
        w_wave = {~i_phase[BITS-2:0], 1'b0};
      end else begin
        w_wave = {i_phase[BITS-2:0], 1'b0};
      end
    end else begin
      w_wave = i_phase;
    end
    o_contrib = w_wave >> i_amp_shift;
  end

endmodule

// File: rtl/pwls_mc_sequencer.sv
// Multichannel phase-accumulator sequencer: one channel per cycle per sweep, mixed
// into one sample. Triangle mode exists only when PWLS_SEQ_TRI_EN is defined.
module pwls_mc_sequencer
  import pwls_seq_pkg::*;
#(
  parameter int BITS     = 12,
  parameter int OCT_BITS = 3,
  parameter int NUM_CH   = 4,
  localparam int CH_BITS = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_tick,
  input  logic                    reg_we,
  input  logic [CH_BITS+1:0]      reg_waddr,
  input  logic [BITS-1:0]         reg_wdata,
  output logic [BITS+CH_BITS-1:0] sample_out,
  output logic                    sample_valid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int ACC_W = BITS + CH_BITS;
  localparam logic [OCT_BITS-1:0] MAX_OCT = '1;
  localparam logic [CH_BITS-1:0]  LAST_CH = CH_BITS'(NUM_CH - 1);

  logic [BITS-2:0]     r_mant  [NUM_CH];
  logic [OCT_BITS-1:0] r_oct   [NUM_CH];
  logic [2:0]          r_amp   [NUM_CH];
  logic [BITS-1:0]     r_phase [NUM_CH];

  seq_state_e          r_state;
  logic [CH_BITS-1:0]  r_ch;
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    r_sample_out;
  logic                r_valid;
  logic                r_busy;
  logic                r_overrun;

  logic [CH_BITS-1:0]  w_wch;
  logic [1:0]          w_field;
  logic                w_sweep;
  logic                w_mode;
  logic [BITS-1:0]     w_step;
  logic [BITS-1:0]     w_phase_next;
  logic [BITS-1:0]     w_contrib;
  logic [ACC_W-1:0]    w_sum;

  assign w_wch        = reg_waddr[CH_BITS+1:2];
  assign w_field      = reg_waddr[1:0];
  assign w_sweep      = (r_state == ST_SWEEP);
  assign w_step       = {1'b1, r_mant[r_ch]} >> (MAX_OCT - r_oct[r_ch]);
  assign w_phase_next = r_phase[r_ch] + w_step;
  assign w_sum        = r_acc + ACC_W'(w_contrib);

`ifdef PWLS_SEQ_TRI_EN
  logic r_mode [NUM_CH];

  // Mode bit storage, only present when triangle support is built in.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) r_mode[c] <= MODE_SAW;
    end else if (reg_we && w_field == FIELD_AMP) begin
      r_mode[w_wch] <= reg_wdata[3];
    end else begin
      r_mode[w_wch] <= r_mode[w_wch];
    end
  end

  assign w_mode = r_mode[r_ch];
`else
  assign w_mode = MODE_SAW;
`endif

  pwls_seq_wave #(.BITS(BITS)) u_wave (
    .i_phase     (r_phase[r_ch]),
    .i_mode      (w_mode),
    .i_amp_shift (r_amp[r_ch]),
    .o_contrib   (w_contrib)
  );

  // Channel registers; a phase write overrides the same-cycle sweep advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_mant[c]  <= '0;
        r_oct[c]   <= '0;
        r_amp[c]   <= 3'd0;
        r_phase[c] <= '0;
      end
    end else begin
      if (w_sweep) begin
        r_phase[r_ch] <= w_phase_next;
      end
      if (reg_we) begin
        case (w_field)
          FIELD_MANT:  r_mant[w_wch]  <= reg_wdata[BITS-2:0];
          FIELD_OCT:   r_oct[w_wch]   <= reg_wdata[OCT_BITS-1:0];
          FIELD_AMP:   r_amp[w_wch]   <= reg_wdata[2:0];
          FIELD_PHASE: r_phase[w_wch] <= reg_wdata;
          default:     r_amp[w_wch]   <= r_amp[w_wch];
        endcase
      end
    end
  end

  // Sweep FSM, mix accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_ch         <= '0;
      r_acc        <= '0;
      r_sample_out <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (sample_tick && r_state != ST_IDLE) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (sample_tick) begin
            r_state <= ST_SWEEP;
            r_ch    <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_SWEEP: begin
          r_acc <= w_sum;
          r_ch  <= r_ch + CH_BITS'(1);
          if (r_ch == LAST_CH) begin
            r_state      <= ST_DONE;
            r_sample_out <= w_sum;
            r_valid      <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sample_out   = r_sample_out;
  assign sample_valid = r_valid;
  assign busy         = r_busy;
  assign overrun      = r_overrun;

endmodule

// File: doc/pwls_mc_sequencer.md
PWLS_MC_SEQUENCER -- requirements
Module: pwls_mc_sequencer

Interface
REQ-001 SHALL have parameter BITS, default 12: phase and waveform width.
REQ-002 SHALL have parameter OCT_BITS, default 3: octave field width.
REQ-003 SHALL have parameter NUM_CH, default 4: channel count, power of two, at least 2; CH_BITS = log2(NUM_CH).
REQ-004 SHALL have port clk, input, 1: the only clock.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high.
REQ-006 SHALL have port sample_tick, input, 1: starts one sample sweep.
REQ-007 SHALL have port reg_we, input, 1: register write strobe.
REQ-008 SHALL have port reg_waddr, input, CH_BITS+2: {channel, field}.
REQ-009 SHALL have port reg_wdata, input, BITS: write data.
REQ-010 SHALL have port sample_out, output, BITS+CH_BITS: mixed sample.
REQ-011 SHALL have port sample_valid, output, 1: one-cycle pulse when sample_out updates.
REQ-012 SHALL have port busy, output, 1: high in SWEEP and DONE.
REQ-013 SHALL have port overrun, output, 1: sticky flag for a tick ignored while busy.

Function
REQ-014 SHALL keep per-channel registers: mantissa (BITS-1), octave (OCT_BITS), amp_shift (3), mode (1), phase (BITS).
REQ-015 SHALL decode write fields by field value: 0 = mantissa = wdata[BITS-2:0]; 1 = octave = wdata[OCT_BITS-1:0]; 2 = amp_shift = wdata[2:0] and mode = wdata[3]; 3 = phase = wdata.
REQ-016 SHALL implement states IDLE, SWEEP and DONE.
REQ-017 In IDLE, sample_tick SHALL cause SWEEP next cycle, with channel counter at 0 and the mix accumulator cleared.
REQ-018 SHALL spend exactly one cycle per channel in SWEEP, channel 0 first; after channel NUM_CH-1 it SHALL go to DONE, then DONE SHALL go to IDLE.
REQ-019 For the serviced channel, step SHALL be {1'b1, mantissa} >> ((2^OCT_BITS - 1) - octave).
REQ-020 The serviced channel's phase SHALL become (phase + step) mod 2^BITS.
REQ-021 The waveform SHALL be computed from the pre-update phase. Saw (mode 0) = phase. Triangle (mode 1) = phase[BITS-1] ? {~phase[BITS-2:0], 1'b0} : {phase[BITS-2:0], 1'b0}.
REQ-022 Each channel SHALL add (waveform >> amp_shift), zero-extended, into the mix accumulator, which is BITS+CH_BITS wide and cannot overflow.
REQ-023 In DONE, sample_out SHALL register the full accumulator sum and sample_valid SHALL be 1 for that cycle only.
REQ-024 Latency SHALL be: tick in cycle t gives sample_valid in cycle t+NUM_CH+1; the minimum tick spacing is NUM_CH+2 cycles.
REQ-025 sample_tick in SWEEP or DONE SHALL be ignored and SHALL set overrun; overrun clears only on reset.
REQ-026 A phase-field write to the channel serviced in the same cycle SHALL win over the accumulator update.
REQ-027 Other field writes to the channel serviced in the same cycle SHALL take effect from the next sweep; the current update SHALL use the old values.
REQ-028 Writes SHALL be accepted in every state.

Reset
REQ-029 Reset SHALL clear all channel registers, the accumulator, sample_out, sample_valid, busy and overrun to 0, and set the state to IDLE.
REQ-030 Reset mid-sweep SHALL abort the sweep without a sample_valid pulse; reset SHALL dominate a simultaneous tick or write.

Configuration
REQ-031 Macro PWLS_SEQ_TRI_EN defined: triangle mode as in REQ-021.
REQ-032 Macro PWLS_SEQ_TRI_EN undefined: the mode bit SHALL not be stored and all channels SHALL output saw; field 2 bit 3 SHALL be ignored.

Structure
REQ-033 Package pwls_seq_pkg SHALL hold the state enum, the field-code constants (FIELD_MANT, FIELD_OCT, FIELD_AMP, FIELD_PHASE) and the waveform-mode constants.
REQ-034 One sub-module, pwls_seq_wave, SHALL be combinational: phase, mode and amp_shift in, scaled contribution out.

Verification (BITS=12, OCT_BITS=3, NUM_CH=4, after reset)
REQ-035 Ch0 octave=7, mantissa=0: after three ticks, ch0 contributions SHALL be 0x000, 0x800, 0x000 (wrap); each sample_valid SHALL come 5 cycles after its tick.
REQ-036 All channels at reset values, one tick: sample_out SHALL be 0. A second tick SHALL give 4*0x010 = 0x040, since step = 0x800>>7.
REQ-037 Ch1 phase=0xC00, mode=1, amp_shift=0, one tick: sample_out SHALL be 0x7FE. With PWLS_SEQ_TRI_EN undefined it SHALL be 0xC00.
REQ-038 Ch2 amp_shift=2, phase=0x800, other channels at phase 0: sample_out SHALL be 0x200.
REQ-039 Tick at t, tick again at t+2: overrun SHALL be 1, only one sample_valid SHALL occur, and busy SHALL be high for cycles t+1 to t+5.
REQ-040 Reset asserted at t+2 after a tick at t: no sample_valid, and all outputs SHALL read 0 at t+3.
